// File: rtl/exm_div_arbiter.sv
// exm_div_arbiter: shares one iterative divider between the two EXM lanes.
// Ports: reqN_* lane requests in, rspN_ok/rspN_result held results out,
// div_* launch/abort bus to the divider, div_done/div_result back from it,
// adv/flush pipeline control, clk and async active-high reset.
module exm_div_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_mod,
    input  logic              req0_unsigned,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    input  logic              req1_mod,
    input  logic              req1_unsigned,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic              adv,
    input  logic              flush,
    output logic              rsp0_ok,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp1_ok,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              div_start,
    output logic              div_mod,
    output logic              div_unsigned,
    output logic [DATA_W-1:0] div_src1,
    output logic [DATA_W-1:0] div_src2,
    output logic              div_cancel,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } st_t;

    st_t               st;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] res0;
    logic [DATA_W-1:0] res1;
    logic              start_q;
    logic              mod_q;
    logic              uns_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;

    logic elig0;
    logic elig1;
    logic own_req;
    logic busy;
    logic kill;
    logic cap0;
    logic cap1;

    assign elig0 = req0_valid & ~done0 & ~flush;
    assign elig1 = req1_valid & ~done1 & ~flush;
    assign busy  = (st != IDLE);

    always_comb begin
        own_req = 1'b0;
        unique case (st)
            BUSY0:   own_req = req0_valid;
            BUSY1:   own_req = req1_valid;
            default: own_req = 1'b0;
        endcase
    end

    // Operation in flight must be abandoned: flush or owner lane dropped.
    assign kill = busy & (flush | ~own_req);

    // Flush beats div_done; a dropped request discards the result too.
    assign cap0 = (st == BUSY0) & div_done & req0_valid & ~flush;
    assign cap1 = (st == BUSY1) & div_done & req1_valid & ~flush;

    // A kill in the launch cycle withdraws the launch instead of
    // aborting it, so start and cancel never coincide.
    assign div_start  = start_q & ~kill;
    assign div_cancel = kill & ~start_q;

    assign div_mod      = mod_q;
    assign div_unsigned = uns_q;
    assign div_src1     = src1_q;
    assign div_src2     = src2_q;
    assign rsp0_ok      = done0;
    assign rsp1_ok      = done1;
    assign rsp0_result  = res0;
    assign rsp1_result  = res1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            done0   <= 1'b0;
            done1   <= 1'b0;
            res0    <= '0;
            res1    <= '0;
            start_q <= 1'b0;
            mod_q   <= 1'b0;
            uns_q   <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (elig0) begin
                        st      <= BUSY0;
                        start_q <= 1'b1;
                        mod_q   <= req0_mod;
                        uns_q   <= req0_unsigned;
                        src1_q  <= req0_src1;
                        src2_q  <= req0_src2;
                    end else if (elig1) begin
                        st      <= BUSY1;
                        start_q <= 1'b1;
                        mod_q   <= req1_mod;
                        uns_q   <= req1_unsigned;
                        src1_q  <= req1_src1;
                        src2_q  <= req1_src2;
                    end
                end
                BUSY0, BUSY1: begin
                    if (kill | cap0 | cap1) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase

            if (cap0) begin
                res0 <= div_result;
            end
            if (cap1) begin
                res1 <= div_result;
            end

            if (flush) begin
                done0 <= 1'b0;
            end else if (cap0) begin
                done0 <= 1'b1;
            end else if (adv | ~req0_valid) begin
                done0 <= 1'b0;
            end

            if (flush) begin
                done1 <= 1'b0;
            end else if (cap1) begin
                done1 <= 1'b1;
            end else if (adv | ~req1_valid) begin
                done1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exm_div_arbiter.sv
// tb_exm_div_arbiter: directed and randomized checks of exm_div_arbiter
// against a lane-level reference model and a latency-configurable divider.
module tb_exm_div_arbiter;

    logic        clk;
    logic        reset;
    logic        rv [2];
    logic        rm [2];
    logic        ru [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic        adv;
    logic        flush;
    logic        rsp0_ok;
    logic [31:0] rsp0_result;
    logic        rsp1_ok;
    logic [31:0] rsp1_result;
    logic        div_start;
    logic        div_mod;
    logic        div_unsigned;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_cancel;
    logic        div_done;
    logic [31:0] div_result;

    exm_div_arbiter #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (rv[0]),
        .req0_mod     (rm[0]),
        .req0_unsigned(ru[0]),
        .req0_src1    (ra[0]),
        .req0_src2    (rb[0]),
        .req1_valid   (rv[1]),
        .req1_mod     (rm[1]),
        .req1_unsigned(ru[1]),
        .req1_src1    (ra[1]),
        .req1_src2    (rb[1]),
        .adv          (adv),
        .flush        (flush),
        .rsp0_ok      (rsp0_ok),
        .rsp0_result  (rsp0_result),
        .rsp1_ok      (rsp1_ok),
        .rsp1_result  (rsp1_result),
        .div_start    (div_start),
        .div_mod      (div_mod),
        .div_unsigned (div_unsigned),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .div_cancel   (div_cancel),
        .div_done     (div_done),
        .div_result   (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // divider model
    bit          dv_busy;
    int          dv_cnt;
    int          dv_lat;
    logic [31:0] dv_res;

    // lane-level reference model
    bit          m_busy;
    bit          m_ln;
    bit          fresh;
    bit          m_ok [2];
    logic [31:0] m_res [2];
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic        lat_m;
    logic        lat_u;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic m, input logic u);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return m ? a : 32'hFFFF_FFFF;
        if (u) return m ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return m ? 32'h0 : a;
        return m ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_ln     = 1'b0;
        fresh    = 1'b0;
        m_ok[0]  = 1'b0;
        m_ok[1]  = 1'b0;
        m_res[0] = 32'h0;
        m_res[1] = 32'h0;
        lat_a    = 32'h0;
        lat_b    = 32'h0;
        lat_m    = 1'b0;
        lat_u    = 1'b0;
        dv_busy  = 1'b0;
        dv_cnt   = 0;
        div_done = 1'b0;
    endtask

    task automatic chk_reset();
        check("rst_ok0", 32'(rsp0_ok), 32'h0);
        check("rst_ok1", 32'(rsp1_ok), 32'h0);
        check("rst_res0", rsp0_result, 32'h0);
        check("rst_res1", rsp1_result, 32'h0);
        check("rst_start", 32'(div_start), 32'h0);
        check("rst_cancel", 32'(div_cancel), 32'h0);
        check("rst_src1", div_src1, 32'h0);
        check("rst_src2", div_src2, 32'h0);
        check("rst_mod", 32'(div_mod), 32'h0);
        check("rst_uns", 32'(div_unsigned), 32'h0);
    endtask

    // One clock cycle: divider responds, outputs checked, model advances.
    task automatic cycle();
        bit kill;
        bit cap;
        bit e0;
        bit e1;
        div_done   = 1'b0;
        div_result = $urandom;
        if (dv_busy) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                div_done   = 1'b1;
                div_result = dv_res;
                dv_busy    = 1'b0;
            end
        end
        #1;
        kill = m_busy && (flush || !rv[m_ln]);
        check("rsp0_ok", 32'(rsp0_ok), 32'(m_ok[0]));
        check("rsp1_ok", 32'(rsp1_ok), 32'(m_ok[1]));
        check("rsp0_result", rsp0_result, m_res[0]);
        check("rsp1_result", rsp1_result, m_res[1]);
        check("div_start", 32'(div_start), 32'(m_busy && fresh && !kill));
        check("div_cancel", 32'(div_cancel), 32'(m_busy && !fresh && kill));
        check("div_src1", div_src1, lat_a);
        check("div_src2", div_src2, lat_b);
        check("div_mod", 32'(div_mod), 32'(lat_m));
        check("div_uns", 32'(div_unsigned), 32'(lat_u));

        if (div_cancel) dv_busy = 1'b0;
        if (div_start) begin
            dv_busy = 1'b1;
            dv_cnt  = dv_lat;
            dv_res  = ref_div(div_src1, div_src2, div_mod, div_unsigned);
        end

        cap = m_busy && !kill && div_done;
        e0  = rv[0] && !m_ok[0] && !flush;
        e1  = rv[1] && !m_ok[1] && !flush;
        if (flush) m_ok[0] = 1'b0;
        else if (cap && !m_ln) m_ok[0] = 1'b1;
        else if (adv || !rv[0]) m_ok[0] = 1'b0;
        if (flush) m_ok[1] = 1'b0;
        else if (cap && m_ln) m_ok[1] = 1'b1;
        else if (adv || !rv[1]) m_ok[1] = 1'b0;
        if (cap) m_res[m_ln] = ref_div(ra[m_ln], rb[m_ln], rm[m_ln], ru[m_ln]);
        if (m_busy) begin
            if (kill || cap) m_busy = 1'b0;
            fresh = 1'b0;
        end else if (e0 || e1) begin
            m_ln   = !e0;
            m_busy = 1'b1;
            fresh  = 1'b1;
            lat_a  = ra[m_ln];
            lat_b  = rb[m_ln];
            lat_m  = rm[m_ln];
            lat_u  = ru[m_ln];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lane(input int n, input logic [31:0] a,
                            input logic [31:0] b, input logic m,
                            input logic u);
        rv[n] = 1'b1;
        ra[n] = a;
        rb[n] = b;
        rm[n] = m;
        ru[n] = u;
    endtask

    task automatic retire();
        adv = 1'b1;
        cycle();
        adv   = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        cycle();
    endtask

    bit p_adv;
    bit p_flush;
    bit pre_ok [2];

    initial begin
        reset = 1'b1;
        adv   = 1'b0;
        flush = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rv[n] = 1'b0;
            rm[n] = 1'b0;
            ru[n] = 1'b0;
            ra[n] = 32'h0;
            rb[n] = 32'h0;
        end
        div_result = 32'h0;
        dv_lat     = 4;
        model_reset();
        @(negedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // reset in the middle of BUSY0 with lane 1 holding a result
        dv_lat = 2;
        set_lane(1, 32'd9, 32'd3, 1'b0, 1'b1);
        repeat (5) cycle();
        check("pre_rst_ok1", 32'(rsp1_ok), 32'h1);
        dv_lat = 4;
        set_lane(0, 32'd50, 32'd5, 1'b0, 1'b1);
        repeat (2) cycle();
        reset = 1'b1;
        #1;
        chk_reset();
        model_reset();
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) cycle();

        // single lane 0: 100 / 7 unsigned
        set_lane(0, 32'd100, 32'd7, 1'b0, 1'b1);
        cycle();
        check("t2_start", 32'(div_start), 32'h1);
        check("t2_src1", div_src1, 32'd100);
        check("t2_src2", div_src2, 32'd7);
        repeat (4) cycle();
        check("t2_early", 32'(rsp0_ok), 32'h0);
        cycle();
        check("t2_ok", 32'(rsp0_ok), 32'h1);
        check("t2_res", rsp0_result, 32'd14);
        repeat (3) cycle();
        check("t2_hold", 32'(rsp0_ok), 32'h1);
        adv = 1'b1;
        cycle();
        adv   = 1'b0;
        rv[0] = 1'b0;
        check("t2_adv", 32'(rsp0_ok), 32'h0);
        cycle();

        // contention: lane 0 -7 rem 2 signed, lane 1 9 / 3
        set_lane(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        set_lane(1, 32'd9, 32'd3, 1'b0, 1'b0);
        repeat (6) cycle();
        check("t3_ok0", 32'(rsp0_ok), 32'h1);
        check("t3_res0", rsp0_result, 32'hFFFF_FFFF);
        cycle();
        check("t3_start1", 32'(div_start), 32'h1);
        check("t3_src1", div_src1, 32'd9);
        repeat (5) cycle();
        check("t3_ok1", 32'(rsp1_ok), 32'h1);
        check("t3_res1", rsp1_result, 32'd3);
        retire();

        // flush in BUSY1 on the div_done cycle
        set_lane(1, 32'd77, 32'd7, 1'b0, 1'b1);
        repeat (5) cycle();
        flush = 1'b1;
        #1;
        check("t4_cancel", 32'(div_cancel), 32'h1);
        cycle();
        flush = 1'b0;
        check("t4_ok1", 32'(rsp1_ok), 32'h0);
        cycle();
        check("t4_regrant", 32'(div_start), 32'h1);
        repeat (6) cycle();
        retire();

        // lane 0 abandons mid-BUSY0 while lane 1 waits
        set_lane(0, 32'd40, 32'd4, 1'b0, 1'b1);
        set_lane(1, 32'd30, 32'd6, 1'b0, 1'b1);
        repeat (3) cycle();
        rv[0] = 1'b0;
        #1;
        check("t5_cancel", 32'(div_cancel), 32'h1);
        repeat (2) cycle();
        check("t5_start1", 32'(div_start), 32'h1);
        check("t5_src1", div_src1, 32'd30);
        repeat (6) cycle();
        retire();

        // back-to-back lane 0 divides
        set_lane(0, 32'd60, 32'd7, 1'b1, 1'b1);
        repeat (7) cycle();
        adv = 1'b1;
        cycle();
        adv = 1'b0;
        set_lane(0, 32'd1000, 32'd10, 1'b0, 1'b1);
        check("t6_gap", 32'(rsp0_ok), 32'h0);
        cycle();
        check("t6_start", 32'(div_start), 32'h1);
        check("t6_src1", div_src1, 32'd1000);
        repeat (5) cycle();
        check("t6_ok", 32'(rsp0_ok), 32'h1);
        check("t6_res", rsp0_result, 32'd100);
        retire();

        // randomized traffic
        p_adv   = 1'b0;
        p_flush = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if ((p_adv || p_flush) && rv[n] && !pre_ok[n]) begin
                    rv[n] = 1'b0;
                end else if (!rv[n] || p_adv || p_flush) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_lane(n, pick(), pick(),
                                 ($urandom_range(0, 1) == 1),
                                 ($urandom_range(0, 1) == 1));
                    end else begin
                        rv[n] = 1'b0;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    rv[n] = 1'b0;
                end
            end
            adv       = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            dv_lat    = $urandom_range(1, 6);
            pre_ok[0] = m_ok[0];
            pre_ok[1] = m_ok[1];
            cycle();
            p_adv   = adv;
            p_flush = flush;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exm_div_arbiter.md
# exm_div_arbiter

Shares one iterative divider between the two EXM_stage lanes of the dual-issue core. Each lane presents the request it currently drives on its divider bus. The block grants the divider to one lane at a time, with lane 0 (older in program order) winning ties. It launches the operation, captures the result, and holds each lane's result and `ok` flag until the pipeline advances. A flush from exception or branch handling aborts any operation in flight.

## Interface
- `DATA_W`, 32, operand and result width.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high.
- `req0_valid` in 1: lane 0 requests a divide. Must be held with stable operands until `rsp0_ok` or `adv`.
- `req0_mod` in 1: 1 means remainder, 0 means quotient.
- `req0_unsigned` in 1: unsigned operation.
- `req0_src1` in DATA_W: dividend.
- `req0_src2` in DATA_W: divisor.
- `req1_valid`, `req1_mod`, `req1_unsigned`, `req1_src1`, `req1_src2`: same as lane 0, for lane 1.
- `adv` in 1: pipeline advances both lanes this cycle (both lanes ok and WB ready).
- `flush` in 1: kill all work.
- `rsp0_ok` out 1: lane 0 result valid (level).
- `rsp0_result` out DATA_W: lane 0 result.
- `rsp1_ok`, `rsp1_result`: same, for lane 1.
- `div_start` out 1: one-cycle launch pulse to the divider.
- `div_mod`, `div_unsigned` out 1: latched operation attributes.
- `div_src1`, `div_src2` out DATA_W: latched operands.
- `div_cancel` out 1: one-cycle abort pulse to the divider.
- `div_done` in 1: divider completion pulse.
- `div_result` in DATA_W: divider result, valid while `div_done` is high.

## Operation
- State register `st` ∈ {IDLE, BUSY0, BUSY1}. Per-lane flags `done0` and `done1` drive `rspN_ok` directly. Per-lane result registers drive `rspN_result`.
- A lane is eligible when `reqN_valid & ~doneN & ~flush`.
- IDLE:
  - If lane 0 is eligible: latch lane 0 operands and attributes into the `div_*` registers, go to BUSY0.
  - Otherwise, if lane 1 is eligible: same for lane 1, go to BUSY1.
  - Otherwise: stay in IDLE.
- BUSYn, first cycle: `div_start`=1. `div_*` outputs stay constant for the whole of BUSYn.
- BUSYn, when `div_done`=1:
  - result register n ← `div_result`; `doneN` ← 1; `st` → IDLE.
  - The other lane, if eligible, is granted in that IDLE cycle, so there is exactly one idle cycle between operations.
- BUSYn, when `reqN_valid` drops (lane killed or abandoned): `div_cancel`=1 for one cycle, `st` → IDLE, `doneN` unchanged (0).
- `flush`:
  - Takes effect at the next edge: `st` → IDLE, `done0` and `done1` ← 0.
  - `div_cancel`=1 combinationally in that cycle if `st`≠IDLE.
  - Flush has priority over `div_done` in the same cycle; the result is discarded.
- `adv`: clears `done0` and `done1` at the next edge, so a lane whose next instruction is also a divide becomes eligible one cycle later.
- `doneN` also clears whenever `reqN_valid`=0.
- `adv` and `div_done` in the same cycle: capture takes priority for the granted lane's `done` flag only if that lane's `req` is still high. Otherwise it is cleared.
- Division by zero and signedness are the divider's concern. Results pass through unmodified.

## Timing
- Reset (async) values:
  - `st`=IDLE.
  - `rsp0_ok`=`rsp1_ok`=0, `rsp0_result`=`rsp1_result`=0.
  - `div_start`=`div_cancel`=0, `div_src1`=`div_src2`=0, `div_mod`=`div_unsigned`=0.
- `div_start` is a registered pulse, asserted in the first BUSY cycle.
- Latency for an uncontended request with divider latency L (cycles from `div_start` to `div_done`):
  - request seen in cycle t → `div_start` at t+1 → `div_done` at t+1+L → `rspN_ok` high at t+2+L.
- Contended (both lanes request at t, L=L): `rsp0_ok` at t+2+L, `div_start` for lane 1 at t+3+L, `rsp1_ok` at t+4+2L.
- `rspN_ok` stays high, with `rspN_result` stable, until `adv`, `flush`, or `reqN_valid`=0.
- `div_cancel` is never asserted in the same cycle as `div_start`.

## Test plan
- Reset mid-BUSY0: assert `reset` asynchronously → all outputs 0 immediately, `st`=IDLE, no `div_start` after release until a new request.
- Single lane 0 request 100/7 unsigned quotient, model L=4 → `div_start` at t+1 with `div_src1`=100 and `div_src2`=7, `rsp0_ok`=1 with `rsp0_result`=14 at t+6, held until `adv`, then 0.
- Both lanes at t (lane 0: −7 mod 2 signed; lane 1: 9/3), L=4:
  - `rsp0_result`=0xFFFFFFFF (−1) at t+6.
  - lane 1 `div_start` at t+7, `rsp1_result`=3 at t+12.
  - lane 1 operands are never driven before t+7.
- `flush` during BUSY1 in the cycle `div_done`=1 → `div_cancel`=1, `rsp1_ok` stays 0, `st`=IDLE next cycle.
- Lane 0 drops `req0_valid` mid-BUSY0 while lane 1 is requesting → `div_cancel` pulse, lane 1 `div_start` two cycles later, `rsp0_ok` never 1.
- Back-to-back lane 0 divides: `adv` in the cycle after `rsp0_ok`, `req0_valid` held high with new operands → `rsp0_ok` drops for at least one cycle, new `div_start` with the new operands, new result correct.
